// File: rtl/arbiter_types.sv
// rtl/arbiter_types.sv - shared types and limits for the memory-port arbiter
package arbiter_types;

    localparam int ARB_MAX_PORTS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    // Successor of an owner index with wrap at the configured port count.
    function automatic int next_port(input int idx, input int num_ports);
        return (idx + 1 >= num_ports) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational winner search: first requester at or after ptr, wrapping upward
module rr_pick #(
    parameter int NUM_PORTS = 2
) (
    input  logic [NUM_PORTS-1:0]         req,
    input  logic [$clog2(NUM_PORTS)-1:0] ptr,
    output logic                         found,
    output logic [$clog2(NUM_PORTS)-1:0] idx
);

    localparam int IDX_W = $clog2(NUM_PORTS);

    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        found    = 1'b0;
        idx      = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_PORTS) begin
                cand = cand - NUM_PORTS;
            end
            cand_idx = IDX_W'(cand);
            if (!found && req[cand_idx]) begin
                found = 1'b1;
                idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// rtl/mem_arbiter_rr.sv - N-port cache-line arbiter onto one memory port; MEM_ARBITER_FIXED_PRIORITY_EN selects fixed priority
module mem_arbiter_rr
    import arbiter_types::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            port_read,
    input  logic [NUM_PORTS-1:0]            port_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_address,
    input  logic [NUM_PORTS*LINE_WIDTH-1:0] port_wdata,
    output logic [NUM_PORTS-1:0]            port_resp,
    output logic [LINE_WIDTH-1:0]           port_rdata,
    output logic                            pmem_read,
    output logic                            pmem_write,
    output logic [ADDR_WIDTH-1:0]           pmem_address,
    output logic [LINE_WIDTH-1:0]           pmem_wdata,
    input  logic                            pmem_resp,
    input  logic [LINE_WIDTH-1:0]           pmem_rdata,
    output logic                            grant_valid,
    output logic [$clog2(NUM_PORTS)-1:0]    grant_idx
);

    localparam int IDX_W = $clog2(NUM_PORTS);

    if (NUM_PORTS < 2 || NUM_PORTS > ARB_MAX_PORTS) begin : g_bad_num_ports
        $error("mem_arbiter_rr: NUM_PORTS out of range");
    end

    arb_state_t             state;
    logic [IDX_W-1:0]       owner_q;
    logic                   op_write_q;
    logic                   pmem_read_q;
    logic                   pmem_write_q;
    logic                   grant_valid_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [LINE_WIDTH-1:0]  wdata_q;

    logic [NUM_PORTS-1:0]   req_vec;
    logic                   pick_found;
    logic [IDX_W-1:0]       pick_idx;
    logic [IDX_W-1:0]       pick_ptr;

    assign req_vec = port_read | port_write;

`ifdef MEM_ARBITER_FIXED_PRIORITY_EN
    // Search always starts at port 0, so the data cache wins every tie.
    assign pick_ptr = '0;
`else
    logic [IDX_W-1:0] rr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (state == DONE) begin
            rr_ptr <= IDX_W'(next_port(int'(owner_q), NUM_PORTS));
        end
    end

    assign pick_ptr = rr_ptr;
`endif

    rr_pick #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_pick (
        .req   (req_vec),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            owner_q       <= '0;
            op_write_q    <= 1'b0;
            pmem_read_q   <= 1'b0;
            pmem_write_q  <= 1'b0;
            grant_valid_q <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state         <= BUSY;
                        owner_q       <= pick_idx;
                        // A port raising both strobes is serviced as a write.
                        op_write_q    <= port_write[pick_idx];
                        pmem_write_q  <= port_write[pick_idx];
                        pmem_read_q   <= ~port_write[pick_idx];
                        grant_valid_q <= 1'b1;
                        addr_q        <= port_address[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        wdata_q       <= port_wdata[pick_idx*LINE_WIDTH +: LINE_WIDTH];
                    end
                end
                BUSY: begin
                    if (pmem_resp) begin
                        state        <= DONE;
                        pmem_read_q  <= 1'b0;
                        pmem_write_q <= 1'b0;
                    end
                end
                DONE: begin
                    state         <= IDLE;
                    owner_q       <= '0;
                    grant_valid_q <= 1'b0;
                end
                default: begin
                    state         <= IDLE;
                    owner_q       <= '0;
                    pmem_read_q   <= 1'b0;
                    pmem_write_q  <= 1'b0;
                    grant_valid_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        port_resp = '0;
        if (state == BUSY && pmem_resp) begin
            port_resp[owner_q] = 1'b1;
        end
    end

    assign port_rdata   = pmem_rdata;
    assign pmem_read    = pmem_read_q & ~op_write_q;
    assign pmem_write   = pmem_write_q & op_write_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;
    assign grant_valid  = grant_valid_q;
    assign grant_idx    = owner_q;

endmodule

// File: doc/mem_arbiter_rr.md
MEM_ARBITER_RR -- requirements
Module: mem_arbiter_rr

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of requesting cache ports (legal range 2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, physical address width.
REQ-003 SHALL have parameter LINE_WIDTH, default 256, cache line width in bits.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port port_read  input  NUM_PORTS  per-port line read request.
REQ-007 SHALL have port port_write  input  NUM_PORTS  per-port line write request.
REQ-008 SHALL have port port_address  input  NUM_PORTS*ADDR_WIDTH  per-port address, port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 SHALL have port port_wdata  input  NUM_PORTS*LINE_WIDTH  per-port write line, same packing.
REQ-010 SHALL have port port_resp  output  NUM_PORTS  one-hot completion strobe to granted port.
REQ-011 SHALL have port port_rdata  output  LINE_WIDTH  read line, broadcast to all ports.
REQ-012 SHALL have ports pmem_read / pmem_write  output  1 each  memory-side request.
REQ-013 SHALL have ports pmem_address  output  ADDR_WIDTH, pmem_wdata  output  LINE_WIDTH  memory-side address/data.
REQ-014 SHALL have ports pmem_resp  input  1, pmem_rdata  input  LINE_WIDTH  memory-side completion/data.
REQ-015 SHALL have ports grant_valid  output  1, grant_idx  output  $clog2(NUM_PORTS)  current owner.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-017 IDLE: port i requesting when port_read[i] | port_write[i]; any request -> pick winner, register grant_idx, op type, address, wdata; next state BUSY.
REQ-018 Winner SHALL be first requesting port at or after rr_ptr, searching upward with wrap from NUM_PORTS-1 to 0.
REQ-019 BUSY: pmem_read/pmem_write driven from registered op, pmem_address/pmem_wdata from registered copies; stable until pmem_resp.
REQ-020 BUSY with pmem_resp=1: port_resp[grant_idx]=1 same cycle (combinational), port_rdata=pmem_rdata, next state DONE.
REQ-021 DONE: one bubble cycle, no pmem request, port_resp all 0; rr_ptr <= (grant_idx+1) mod NUM_PORTS; next state IDLE.
REQ-022 Latency: request seen in IDLE at cycle t -> pmem request at t+1; next grant earliest 2 cycles after pmem_resp.
REQ-023 Port asserting both read and write SHALL be treated as write.
REQ-024 Requests changing or dropping during BUSY SHALL be ignored; transaction completes from registered copies.
REQ-025 grant_valid=1 exactly in BUSY and DONE; grant_idx holds owner then, 0 otherwise.
REQ-026 pmem_read and pmem_write SHALL never both be 1.

Reset
REQ-027 rst=1 at any edge, including mid-BUSY: state IDLE, rr_ptr 0, all registered copies 0.
REQ-028 During/after reset: pmem_read=0, pmem_write=0, port_resp=0, grant_valid=0, grant_idx=0, pmem_address=0, pmem_wdata=0; an in-flight pmem_resp after reset SHALL be ignored.

Configuration
REQ-029 Macro MEM_ARBITER_FIXED_PRIORITY_EN defined: winner = lowest-index requesting port; rr_ptr not instantiated (port 0 = data cache highest priority).
REQ-030 Macro undefined: round-robin per REQ-018/REQ-021.

Structure
REQ-031 Shared package arbiter_types SHALL hold arb_state_t enum (IDLE, BUSY, DONE) and constant ARB_MAX_PORTS = 8.
REQ-032 Winner selection SHALL be a combinational sub-module rr_pick (inputs req vector, ptr; outputs found, idx), parametrised on NUM_PORTS.

Verification
REQ-033 NUM_PORTS=2; port0 read 0x1000, port1 read 0x2000 same cycle, pmem_resp 3 cycles after request -> port0 served first, then port1; port_resp[1] with rdata of second line.
REQ-034 NUM_PORTS=4, all ports request continuously -> grant order 0,1,2,3,0; no port granted twice before others (round-robin build).
REQ-035 Same stimulus with MEM_ARBITER_FIXED_PRIORITY_EN -> port 0 granted every transaction.
REQ-036 Port 2 write 0x40 with wdata 0xA5..A5, address changed to 0x80 mid-BUSY -> pmem_address stays 0x40, pmem_wdata unchanged.
REQ-037 rst asserted during BUSY, pmem_resp arrives next cycle -> no port_resp, FSM IDLE, grant_valid 0.
REQ-038 Port 1 asserts read and write together -> pmem_write=1, pmem_read=0.
